// File: rtl/cardinal_nic_pkg.sv
// Shared constants and helpers for the cardinal NIC: register map, data width
// and the status-word layout used by both status registers.
package cardinal_nic_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  typedef logic [DATA_W-1:0] word_t;

  // Status registers report their full flag in the MSB, all other bits zero.
  function automatic word_t status_word(input logic full);
    return {full, {(DATA_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/cardinal_nic_channel_buf.sv
// One-packet channel buffer: a data register plus a full flag, filled by
// load and emptied by clear.
module nic_channel_buf
  import cardinal_nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  // NOTE: the data register is reset as well as the flag, so a reset
  // leaves no stale packet readable through the buffer address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal network interface: one-packet input and output channels between a
// processor register port and a router link with virtual-channel polarity.
module cardinal_nic
  import cardinal_nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_ro,
  input  logic              net_polarity,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_dl,
  output logic              net_ri,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  output logic [DATA_W-1:0] d_out
);

  logic              rd_en, wr_en;
  logic              in_load, in_clear, in_full;
  logic              out_load, out_full, send;
  logic [DATA_W-1:0] in_buf, out_buf, rd_data;

  assign rd_en = nicEn & ~nicEnWr;
  assign wr_en = nicEn &  nicEnWr;

  // A packet arriving while full is dropped; the router saw net_ri low.
  assign in_load  = net_si & ~in_full;
  assign in_clear = rd_en & (addr == ADDR_IN_BUF);
  assign net_ri   = ~in_full;

  // out_load needs an empty buffer and send needs a full one, so they never collide.
  assign out_load = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;
  assign send     = out_full & net_ro & (out_buf[DATA_W-1] == net_polarity);

  nic_channel_buf u_in_chan (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clear (in_clear),
    .d     (net_dl),
    .q     (in_buf),
    .full  (in_full)
  );

  nic_channel_buf u_out_chan (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clear (send),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  always_comb begin
    // NOTE: default first so no path through the case leaves rd_data unassigned (no latch).
    rd_data = '0;
    case (addr)
      ADDR_IN_BUF:   rd_data = in_buf;
      ADDR_IN_STAT:  rd_data = status_word(in_full);
      ADDR_OUT_BUF:  rd_data = out_buf;
      ADDR_OUT_STAT: rd_data = status_word(out_full);
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (rd_en) begin
      d_out <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= send;
      if (send) net_do <= out_buf;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios with literal
// expectations plus a randomized phase checked against a packet-level model.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [63:0] d_in = '0;
  logic        nicEn = 1'b0;
  logic        nicEnWr = 1'b0;
  logic        net_ro = 1'b0;
  logic        net_polarity = 1'b0;
  logic        net_si = 1'b0;
  logic [63:0] net_dl = '0;
  logic        net_ri;
  logic        net_so;
  logic [63:0] net_do;
  logic [63:0] d_out;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_ro       (net_ro),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_dl       (net_dl),
    .net_ri       (net_ri),
    .net_so       (net_so),
    .net_do       (net_do),
    .d_out        (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: each channel holds at most one packet; the processor
  // sees the result of a read one edge later.
  logic        m_in_full = 1'b0, m_out_full = 1'b0;
  logic [63:0] m_in_pkt = '0, m_out_pkt = '0;
  logic [63:0] m_d_out = '0, m_net_do = '0;
  logic        m_net_so = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_in_full = 0; m_out_full = 0; m_in_pkt = '0; m_out_pkt = '0;
      m_d_out = '0; m_net_do = '0; m_net_so = 0;
    end else begin
      logic reading, writing, sending, accepting;
      logic [63:0] reg_val [4];
      reg_val[0] = m_in_pkt;
      reg_val[1] = m_in_full ? MSB : 64'd0;
      reg_val[2] = m_out_pkt;
      reg_val[3] = m_out_full ? MSB : 64'd0;
      reading   = nicEn && !nicEnWr;
      writing   = nicEn && nicEnWr && addr == 2'd2 && !m_out_full;
      sending   = m_out_full && net_ro && (m_out_pkt[63] == net_polarity);
      accepting = net_si && !m_in_full;
      if (reading) m_d_out = reg_val[addr];
      m_net_so = sending;
      if (sending) begin m_net_do = m_out_pkt; m_out_full = 0; end
      if (writing) begin m_out_pkt = d_in; m_out_full = 1; end
      if (accepting) begin m_in_pkt = net_dl; m_in_full = 1; end
      else if (reading && addr == 2'd0) m_in_full = 0;
    end
  end

  always @(negedge clk) begin
    check("net_ri", {63'd0, net_ri}, {63'd0, !m_in_full});
    check("net_so", {63'd0, net_so}, {63'd0, m_net_so});
    check("net_do", net_do, m_net_do);
    check("d_out", d_out, m_d_out);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1; nicEnWr = 0; addr = a;
    cyc();
    nicEn = 0;
  endtask

  task automatic wr_out(input logic [63:0] d);
    nicEn = 1; nicEnWr = 1; addr = 2'd2; d_in = d;
    cyc();
    nicEn = 0; nicEnWr = 0;
  endtask

  initial begin
    repeat (5) cyc();
    check("rst_d_out", d_out, 64'd0);
    check("rst_net_so", {63'd0, net_so}, 64'd0);
    check("rst_net_ri", {63'd0, net_ri}, 64'd1);
    reset = 1;

    // Input channel fill, drop of second packet, read-out
    net_si = 1; net_dl = 64'h1;
    cyc();
    check("in_ri_low", {63'd0, net_ri}, 64'd0);
    net_dl = 64'hDEAD;
    cyc();
    net_si = 0;
    rd(2'd1); check("in_stat_full", d_out, MSB);
    rd(2'd0); check("in_buf_read", d_out, 64'h1);
    rd(2'd1); check("in_stat_empty", d_out, 64'd0);

    // Output channel fill without router ready
    rd(2'd3); check("out_stat_empty", d_out, 64'd0);
    wr_out(64'h2);
    rd(2'd3); check("out_stat_full", d_out, MSB);
    check("out_no_send", {63'd0, net_so}, 64'd0);
    wr_out(64'h3);
    rd(2'd2); check("out_wr_ignored", d_out, 64'h2);

    // Polarity gating of the send
    net_ro = 1; net_polarity = 1;
    cyc();
    check("pol_mismatch_so", {63'd0, net_so}, 64'd0);
    rd(2'd3); check("pol_mismatch_full", d_out, MSB);
    net_polarity = 0;
    cyc();
    check("send_so", {63'd0, net_so}, 64'd1);
    check("send_do", net_do, 64'h2);
    cyc();
    check("send_pulse_end", {63'd0, net_so}, 64'd0);
    net_ro = 0;
    rd(2'd3); check("send_cleared", d_out, 64'd0);

    // Same-edge read of input buffer and incoming packet while full
    net_si = 1; net_dl = 64'hAAAA;
    cyc();
    net_dl = 64'hBBBB; nicEn = 1; nicEnWr = 0; addr = 2'd0;
    cyc();
    nicEn = 0; net_si = 0;
    check("same_edge_rd_old", d_out, 64'hAAAA);
    check("same_edge_ri", {63'd0, net_ri}, 64'd1);
    rd(2'd0); check("same_edge_dropped", d_out, 64'hAAAA);

    // Same-edge write and send: send takes old packet, write ignored
    wr_out(64'h11);
    net_ro = 1; net_polarity = 0;
    nicEn = 1; nicEnWr = 1; addr = 2'd2; d_in = 64'h22;
    cyc();
    nicEn = 0; nicEnWr = 0; net_ro = 0;
    check("wr_send_so", {63'd0, net_so}, 64'd1);
    check("wr_send_do", net_do, 64'h11);
    rd(2'd3); check("wr_send_empty", d_out, 64'd0);
    rd(2'd2); check("wr_send_old", d_out, 64'h11);

    // Asynchronous reset with both channels full
    net_si = 1; net_dl = 64'h77;
    wr_out(MSB | 64'h99);
    net_si = 0;
    rd(2'd2); check("pre_rst_d_out", d_out, MSB | 64'h99);
    check("pre_rst_ri", {63'd0, net_ri}, 64'd0);
    #2 reset = 0;
    #1;
    check("async_rst_ri", {63'd0, net_ri}, 64'd1);
    check("async_rst_d_out", d_out, 64'd0);
    check("async_rst_so", {63'd0, net_so}, 64'd0);
    cyc();
    reset = 1;
    rd(2'd3); check("post_rst_out_stat", d_out, 64'd0);
    rd(2'd1); check("post_rst_in_stat", d_out, 64'd0);
    rd(2'd2); check("post_rst_out_buf", d_out, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) != 0);
      addr         = 2'($urandom_range(0, 3));
      nicEn        = ($urandom_range(0, 1) == 1);
      nicEnWr      = ($urandom_range(0, 1) == 1);
      d_in         = {$urandom, $urandom};
      net_ro       = ($urandom_range(0, 2) != 0);
      net_polarity = ($urandom_range(0, 1) == 1);
      net_si       = ($urandom_range(0, 1) == 1);
      net_dl       = {$urandom, $urandom};
      cyc();
    end
    reset = 1; nicEn = 0; net_si = 0; net_ro = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
